ifu_pf: RTL and testbench
=========================

IFU_PF -- requirements
Module: ifu_pf

Interface
- REQ-001 SHALL have parameter ADDR_W, default 32: fetch address width.
- REQ-002 SHALL have parameter DATA_W, default 32: instruction width.
- REQ-003 SHALL have parameter FIFO_DEPTH, default 4: prefetch entries; power of two, >= 2.
- REQ-004 SHALL have parameter RESET_PC, default 32'h8000_0000: first fetch address.
- REQ-005 SHALL have ports, in this order (one clock; reset synchronous, active-high):
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  branch_en_i  in  1  redirect strobe
  dnpc_i  in  ADDR_W  redirect target
  araddr_o  out  ADDR_W  read address
  arvalid_o  out  1  address valid
  arready_i  in  1  address accepted
  rdata_i  in  DATA_W  read data
  rresp_i  in  2  read response, 0 = OKAY
  rvalid_i  in  1  data valid
  rready_o  out  1  data accepted
  valid_post_o  out  1  instruction available downstream
  ready_post_i  in  1  downstream accepts
  pc_o  out  ADDR_W  PC of head entry
  inst_o  out  DATA_W  instruction of head entry
  fault_o  out  1  head entry carries a bus error

Function
- REQ-006 SHALL keep at most one read outstanding; FSM states: IDLE, AR, R, DRAIN, HALT.
- REQ-007 IDLE->AR when (fifo_count + 0) < FIFO_DEPTH, i.e. a free slot is reserved for every issued read.
- REQ-008 AR: arvalid_o=1, araddr_o=fetch_pc held stable until arready_i; on handshake -> R.
- REQ-009 R: rready_o=1; on rvalid_i push {fetch_pc, rdata_i, rresp_i!=0}; fetch_pc += 4 (wraps modulo 2^ADDR_W); -> IDLE, or HALT if rresp_i != 0.
- REQ-010 HALT: no new reads until redirect.
- REQ-011 Redirect (branch_en_i=1): FIFO flushed that cycle; fetch_pc <= {dnpc_i[ADDR_W-1:2], 2'b00}; flush has priority over same-cycle push and pop.
- REQ-012 Redirect in AR: arvalid_o stays high with old address until accepted (no withdrawal); then -> DRAIN.
- REQ-013 Redirect in R without rvalid_i, or in DRAIN: -> DRAIN; redirect in R with rvalid_i: response discarded, -> IDLE.
- REQ-014 DRAIN: rready_o=1; response discarded, no push, no PC advance; -> IDLE.
- REQ-015 Redirect in IDLE or HALT: -> IDLE; AR with new PC earliest next cycle.
- REQ-016 valid_post_o = FIFO not empty; pc_o/inst_o/fault_o = head entry; pop on valid_post_o && ready_post_i.
- REQ-017 Simultaneous push and pop on a full or empty FIFO SHALL both take effect; count unchanged.
- REQ-018 Latency: AR handshake cycle N, rvalid_i at N+1 -> valid_post_o high at N+2.
- REQ-019 Sustained throughput with zero-wait slave: one instruction per 2 cycles.

Reset
- REQ-020 rst SHALL set state=IDLE, fetch_pc=RESET_PC, FIFO empty, arvalid_o=0, rready_o=0, valid_post_o=0, pc_o/inst_o/fault_o=0.
- REQ-021 First arvalid_o SHALL rise in the first cycle after rst deasserts.
- REQ-022 Reset mid-transaction SHALL abandon the read; no drain afterwards (slave is reset by the same rst).

Configuration
- REQ-023 Macro IFU_PF_PERF_EN defined: adds outputs perf_fetch_o[31:0] (pushed entries) and perf_flush_o[31:0] (redirects), both reset to 0, wrapping.
- REQ-024 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
- REQ-025 Shared defines file SHALL hold RESP_OKAY, default RESET_PC and the FSM state encodings.
- REQ-026 FIFO SHALL be a sub-module ifu_pf_fifo (parameters WIDTH, DEPTH; push, pop, flush, full, empty, count).

Verification
- REQ-027 Reset release, zero-wait slave -> araddr_o=0x80000000 cycle 1; pc_o sequence 0x80000000, 0x80000004, 0x80000008.
- REQ-028 ready_post_i=0 for 20 cycles -> exactly 4 entries held, arvalid_o low; ready_post_i=1 -> entries drain in order.
- REQ-029 branch_en_i with dnpc_i=0x80000102 while in R -> response dropped, next araddr_o=0x80000100, valid_post_o low until its data arrives.
- REQ-030 Redirect while arready_i=0 for 3 cycles -> araddr_o unchanged until handshake, response discarded, then fetch from target.
- REQ-031 rresp_i=2 on fetch at 0x80000008 -> entry with fault_o=1, no further arvalid_o until redirect.
- REQ-032 With IFU_PF_PERF_EN, 10 fetches and 2 redirects -> perf_fetch_o=10, perf_flush_o=2.

Source files
------------

// File: rtl/ifu_pf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pf_pkg
//  Description : Shared definitions for the instruction prefetch unit:
//                bus response codes, default boot PC and FSM state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package ifu_pf_pkg;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam int          STATE_W          = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_AR    = 3'd1,
        ST_R     = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    // Any non-OKAY response marks the fetched word as a bus error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_pf_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pf_fifo
//  Description : Synchronous FIFO holding prefetched {pc, inst, fault} entries.
//                Flush has priority over push/pop. Push and pop in the same
//                cycle both take effect even when full or empty.
//  Ports       : clk, rst, push/din, pop/dout, flush, full, empty, count
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_pf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full  = (r_count == c_cnt_w'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A pop frees the slot the simultaneous push needs; a push supplies the
    // entry the simultaneous pop consumes.
    assign w_do_push = push && (!full  || pop);
    assign w_do_pop  = pop  && (!empty || push);

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifu_pf.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pf
//  Description : Instruction fetch prefetcher. Issues single-outstanding reads
//                on an AXI-like AR/R channel, buffers results in a FIFO and
//                presents them downstream with valid/ready. A redirect flushes
//                the FIFO and restarts fetch at the (word-aligned) target; a
//                read already in flight is drained and discarded. A bus error
//                is delivered as a faulting entry and stops fetch until the
//                next redirect.
//  Ports       : clk, rst                         clock / sync active-high reset
//                branch_en_i, dnpc_i              redirect strobe / target
//                araddr_o, arvalid_o, arready_i   read address channel
//                rdata_i, rresp_i, rvalid_i,      read data channel
//                rready_o
//                valid_post_o, ready_post_i,      downstream instruction stream
//                pc_o, inst_o, fault_o
//                perf_fetch_o, perf_flush_o       only with IFU_PF_PERF_EN
//  Options     : IFU_PF_PERF_EN adds wrapping 32-bit counters of pushed
//                entries and redirects.
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_pf
    import ifu_pf_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_en_i,
    input  logic [ADDR_W-1:0] dnpc_i,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic              valid_post_o,
    input  logic              ready_post_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic              fault_o
`ifdef IFU_PF_PERF_EN
    ,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_flush_o
`endif
);

    localparam int                c_entry_w = ADDR_W + DATA_W + 1;
    localparam int                c_cnt_w   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(4);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [ADDR_W-1:0]   r_ar_addr;
    logic                r_redir_pend;

    logic                w_slot_free;
    logic                w_issue_idle;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [c_cnt_w-1:0]  w_fifo_count;
    logic [c_entry_w-1:0] w_push_entry;
    logic [c_entry_w-1:0] w_head;
    logic                w_unused;

    // ------------------------------------------------------------------
    // Read request side. IDLE raises arvalid combinationally so that a
    // zero-wait slave sustains one fetch every two cycles; once raised and
    // not accepted, the FSM parks in AR with the address latched so that
    // neither a redirect nor anything else can change or withdraw it.
    // ------------------------------------------------------------------
    assign w_slot_free  = (w_fifo_count < c_cnt_w'(FIFO_DEPTH));
    assign w_issue_idle = !rst && (r_state == ST_IDLE) && w_slot_free && !branch_en_i;

    assign arvalid_o = !rst && ((r_state == ST_AR) || w_issue_idle);
    assign araddr_o  = (r_state == ST_AR) ? r_ar_addr : r_fetch_pc;
    assign rready_o  = !rst && ((r_state == ST_R) || (r_state == ST_DRAIN));

    // Only a response belonging to the current fetch stream is kept.
    assign w_push       = (r_state == ST_R) && rvalid_i && !branch_en_i;
    assign w_push_entry = {r_fetch_pc, rdata_i, resp_is_err(rresp_i)};
    assign w_pop        = valid_post_o && ready_post_i;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue_idle) w_state_nxt = arready_i ? ST_R : ST_AR;
            end
            ST_AR: begin
                if (arready_i) begin
                    w_state_nxt = (r_redir_pend || branch_en_i) ? ST_DRAIN : ST_R;
                end
            end
            ST_R: begin
                if (branch_en_i) begin
                    w_state_nxt = rvalid_i ? ST_IDLE : ST_DRAIN;
                end else if (rvalid_i) begin
                    w_state_nxt = resp_is_err(rresp_i) ? ST_HALT : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // The stale response retires the outstanding read whether or
                // not another redirect arrives alongside it.
                if (rvalid_i) w_state_nxt = ST_IDLE;
            end
            ST_HALT: begin
                if (branch_en_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_ar_addr    <= RESET_PC;
            r_redir_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (branch_en_i) begin
                r_fetch_pc <= {dnpc_i[ADDR_W-1:2], 2'b00};
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + c_pc_step;
            end

            if (w_issue_idle) r_ar_addr <= r_fetch_pc;

            // Remembers a redirect seen while the old request waits in AR.
            if ((r_state == ST_AR) && !arready_i) begin
                r_redir_pend <= r_redir_pend | branch_en_i;
            end else begin
                r_redir_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefetch buffer
    // ------------------------------------------------------------------
    ifu_pf_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_push_entry),
        .pop   (w_pop),
        .flush (branch_en_i),
        .dout  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // Head fields read as zero whenever nothing is buffered.
    assign valid_post_o = !w_fifo_empty;

    always_comb begin
        pc_o    = '0;
        inst_o  = '0;
        fault_o = 1'b0;
        if (valid_post_o) begin
            pc_o    = w_head[c_entry_w-1 -: ADDR_W];
            inst_o  = w_head[DATA_W:1];
            fault_o = w_head[0];
        end
    end

    assign w_unused = ^{dnpc_i[1:0], w_fifo_full};

`ifdef IFU_PF_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_push)      r_perf_fetch <= r_perf_fetch + 32'd1;
            if (branch_en_i) r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_flush_o = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_pf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu_pf
//  Description : Self-checking bench for ifu_pf. A bus slave with adjustable
//                address stall and response latency feeds the prefetcher; a
//                stream model (expected next PC, memory contents, error
//                address) checks the head entry every cycle it is valid,
//                alongside directed literal checks of the key scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifu_pf;

    localparam logic [31:0] c_reset_pc = 32'h8000_0000;
    localparam logic [31:0] c_no_err   = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_en_i;
    logic [31:0] dnpc_i;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i;
    logic        rready_o;
    logic        valid_post_o;
    logic        ready_post_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        fault_o;
`ifdef IFU_PF_PERF_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_flush_o;
`endif

    always #5 clk = ~clk;

    ifu_pf #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .FIFO_DEPTH (4),
        .RESET_PC   (c_reset_pc)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_en_i  (branch_en_i),
        .dnpc_i       (dnpc_i),
        .araddr_o     (araddr_o),
        .arvalid_o    (arvalid_o),
        .arready_i    (arready_i),
        .rdata_i      (rdata_i),
        .rresp_i      (rresp_i),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o),
        .valid_post_o (valid_post_o),
        .ready_post_i (ready_post_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .fault_o      (fault_o)
`ifdef IFU_PF_PERF_EN
        ,
        .perf_fetch_o (perf_fetch_o),
        .perf_flush_o (perf_flush_o)
`endif
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    // stream model and slave state
    logic [31:0] exp_pc;
    logic [31:0] err_addr;
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_wait;
    int          rlat;
    int          ar_stall;
    bit          prev_stuck;
    logic [31:0] prev_addr;

    // per-cycle observations
    bit          ev_hs, ev_pop, ev_valid, ev_arvalid, ev_arready, ev_fault;
    logic [31:0] ev_hs_addr, ev_araddr, ev_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle, entered and left just after a falling edge. Drives
    // the slave, checks the settled outputs against the stream model, then
    // advances the model by what the next rising edge commits.
    task automatic cycle();
        arready_i = (ar_stall == 0);
        if (pend && pend_wait == 0) begin
            rvalid_i = 1'b1;
            rdata_i  = mem_word(pend_addr);
            rresp_i  = (pend_addr == err_addr) ? 2'd2 : 2'd0;
        end else begin
            rvalid_i = 1'b0;
            rdata_i  = '0;
            rresp_i  = 2'd0;
        end
        #1;
        ev_arvalid = arvalid_o;
        ev_arready = arready_i;
        ev_araddr  = araddr_o;
        ev_valid   = valid_post_o;
        ev_pc      = pc_o;
        ev_fault   = fault_o;
        ev_hs      = !rst && arvalid_o && arready_i;
        ev_hs_addr = araddr_o;
        ev_pop     = !rst && valid_post_o && ready_post_i && !branch_en_i;

        if (!rst) begin
            if (prev_stuck) begin
                chk("ar_hold_valid", arvalid_o, 1'b1);
                chk("ar_hold_addr", araddr_o, prev_addr);
            end
            if (arvalid_o && pend) chk("one_outstanding", 1'b0, 1'b1);
            if (valid_post_o) begin
                chk("head_pc", pc_o, exp_pc);
                chk("head_inst", inst_o, mem_word(exp_pc));
                chk("head_fault", fault_o, (exp_pc == err_addr));
            end
        end

        if (rst) begin
            pend       = 1'b0;
            prev_stuck = 1'b0;
            exp_pc     = c_reset_pc;
        end else begin
            if (rvalid_i && rready_o) pend = 1'b0;
            else if (pend && pend_wait > 0) pend_wait--;
            if (ev_hs) begin
                pend      = 1'b1;
                pend_addr = araddr_o;
                pend_wait = rlat;
            end
            if (arvalid_o && ar_stall > 0) ar_stall--;
            prev_stuck = arvalid_o && !arready_i;
            prev_addr  = araddr_o;
            if (branch_en_i) exp_pc = {dnpc_i[31:2], 2'b00};
            else if (ev_pop) exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_hs(input string name);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!ev_hs && n < 40);
        chk(name, ev_hs, 1'b1);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        branch_en_i = 1'b1;
        dnpc_i      = tgt;
        cycle();
        branch_en_i = 1'b0;
    endtask

    // Redirect in the cycle after a handshake (DUT in R), with the response
    // either later (lat>0) or in that same cycle (lat=0).
    task automatic redirect_in_r(input int lat, input logic [31:0] tgt,
                                 input logic [31:0] exp_addr);
        int n;
        bit early;
        rlat = lat;
        wait_hs("r_pre_hs");
        redirect(tgt);
        n = 0;
        early = 1'b0;
        do begin
            cycle();
            n++;
            if (ev_valid) early = 1'b1;
        end while (!ev_hs && n < 40);
        chk("r_redir_hs", ev_hs, 1'b1);
        chk("r_redir_addr", ev_hs_addr, exp_addr);
        chk("r_no_valid_before_target", early, 1'b0);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!ev_valid && n < 20);
        chk("r_target_valid", ev_valid, 1'b1);
        chk("r_target_pc", ev_pc, exp_addr);
        rlat = 0;
    endtask

    initial begin : main
        int n;
        int pops;
        int stuck;
        int pop_cyc[$];
        logic [31:0] pop_pc[$];

        rst = 1'b1; branch_en_i = 1'b0; dnpc_i = '0; ready_post_i = 1'b0;
        arready_i = 1'b0; rdata_i = '0; rresp_i = '0; rvalid_i = 1'b0;
        rlat = 0; ar_stall = 0; err_addr = c_no_err; pend = 1'b0;
        pend_wait = 0; pend_addr = '0; prev_stuck = 1'b0; prev_addr = '0;
        exp_pc = c_reset_pc;
        @(negedge clk);
        repeat (3) cycle();

        // reset state
        chk("rst_arvalid", arvalid_o, 1'b0);
        chk("rst_rready", rready_o, 1'b0);
        chk("rst_valid_post", valid_post_o, 1'b0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_fault", fault_o, 1'b0);

        // first fetch, latency and throughput with a zero-wait slave
        rst = 1'b0;
        ready_post_i = 1'b1;
        cycle();
        chk("first_arvalid", ev_arvalid, 1'b1);
        chk("first_araddr", ev_araddr, c_reset_pc);
        cycle();
        chk("lat_valid_n1", ev_valid, 1'b0);
        for (int k = 0; k < 30; k++) begin
            if (k > 0) cycle();
            if (k == 0) begin
                cycle();
                chk("lat_valid_n2", ev_valid, 1'b1);
            end
            if (ev_pop) begin
                pop_cyc.push_back(cyc);
                pop_pc.push_back(ev_pc);
            end
        end
        chk("pop_count_ge8", (pop_cyc.size() >= 8), 1'b1);
        if (pop_cyc.size() >= 8) begin
            chk("pop_pc0", pop_pc[0], 32'h8000_0000);
            chk("pop_pc1", pop_pc[1], 32'h8000_0004);
            chk("pop_pc2", pop_pc[2], 32'h8000_0008);
            chk("pop_gap", pop_cyc[1] - pop_cyc[0], 2);
            chk("throughput_8", pop_cyc[7] - pop_cyc[0], 14);
        end

        // backpressure: buffer fills to 4 and fetch stops
        ready_post_i = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (k >= 10 && ev_hs) n++;
        end
        chk("bp_no_fetch", n, 0);
        chk("bp_arvalid_low", ev_arvalid, 1'b0);
        chk("bp_valid", ev_valid, 1'b1);
        ar_stall = 1000;
        ready_post_i = 1'b1;
        pops = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (ev_pop) pops++;
        end
        chk("bp_entries_held", pops, 4);
        ar_stall = 0;

        // redirect while in R: response later, then in the same cycle
        redirect_in_r(2, 32'h8000_0102, 32'h8000_0100);
        redirect_in_r(0, 32'h8000_0402, 32'h8000_0400);

        // redirect while the address waits for arready
        ar_stall = 4;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!ev_arvalid && n < 20);
        chk("stall_arvalid_seen", ev_arvalid, 1'b1);
        redirect(32'h8000_0200);
        stuck = (ev_arvalid && !ev_arready) ? 1 : 0;
        n = 0;
        while (!ev_hs && n < 20) begin
            cycle();
            n++;
            if (ev_arvalid && !ev_arready) stuck++;
        end
        chk("stall_cycles_after_redirect", stuck, 3);
        wait_hs("stall_target_hs");
        chk("stall_target_addr", ev_hs_addr, 32'h8000_0200);

        // bus error at 0x80000008 halts fetch until the next redirect
        err_addr = 32'h8000_0008;
        redirect(32'h8000_0000);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(ev_pop && ev_fault) && n < 40);
        chk("err_fault_popped", ev_pop && ev_fault, 1'b1);
        chk("err_fault_pc", ev_pc, 32'h8000_0008);
        n = 0;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (ev_arvalid) n++;
        end
        chk("err_halted", n, 0);
        err_addr = c_no_err;
        redirect(32'h8000_0300);
        wait_hs("err_resume_hs");
        chk("err_resume_addr", ev_hs_addr, 32'h8000_0300);

        // reset mid-transaction, then 10 pushes and 2 redirects
        rlat = 2;
        wait_hs("mid_hs");
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        rlat = 0;
        ready_post_i = 1'b0;
        cycle();
        chk("rerst_hs", ev_hs, 1'b1);
        chk("rerst_addr", ev_hs_addr, c_reset_pc);
        repeat (19) cycle();
        redirect(32'h8000_1000);
        repeat (20) cycle();
        err_addr = 32'h8000_2004;
        redirect(32'h8000_2000);
        repeat (20) cycle();
        chk("perf_head_pc", ev_pc, 32'h8000_2000);
        chk("perf_halted", ev_arvalid, 1'b0);
`ifdef IFU_PF_PERF_EN
        chk("perf_fetch", perf_fetch_o, 32'd10);
        chk("perf_flush", perf_flush_o, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
